// File: rtl/imm_pkg.sv
// Shared encodings and helpers for the immediate-generator pipeline.
// The optional IMM_GEN_CSR_EN build adds the Z (CSR zimm) format.
`default_nettype none

package imm_pkg;

    localparam int unsigned ILEN = 32;

    typedef logic [2:0] imm_src_t;

    localparam imm_src_t IMM_I = 3'b000;
    localparam imm_src_t IMM_S = 3'b001;
    localparam imm_src_t IMM_B = 3'b010;
    localparam imm_src_t IMM_J = 3'b011;
    localparam imm_src_t IMM_U = 3'b100;
    localparam imm_src_t IMM_Z = 3'b101;

    // Buffered payload is {imm, target, illegal}.
    // The struct itself is declared in the top because its width follows XLEN.
    function automatic int unsigned payload_bits(input int unsigned xlen);
        return 2 * xlen + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between fetch (master) and the immediate-generator pipe (slave).
`default_nettype none

interface imm_gen_pipe_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [ILEN-1:0] instr;
    logic [2:0]      imm_src;
    logic [XLEN-1:0] pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] target;
    logic            illegal;

    modport master (
        output in_valid, instr, imm_src, pc, out_ready,
        input  in_ready, out_valid, imm_ext, target, illegal
    );

    modport slave (
        input  in_valid, instr, imm_src, pc, out_ready,
        output in_ready, out_valid, imm_ext, target, illegal
    );
endinterface

`default_nettype wire

// File: rtl/imm_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with registered upstream ready.
`default_nettype none

module imm_skid_buf #(
    parameter int W = 65
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         i_valid,
    output logic              o_ready,
    input  wire logic [W-1:0] i_data,
    output logic              o_valid,
    input  wire logic         i_ready,
    output logic [W-1:0]      o_data
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic         r_ready;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         w_accept;
    logic         w_emit;
    logic         w_load_main;
    logic         w_load_skid;
    logic         w_skid_to_main;

    assign w_accept = i_valid & r_ready;
    assign w_emit   = (r_state != S_EMPTY) & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != S_FULL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
            S_ONE: begin
                if (w_accept && !w_emit)      w_state_nxt = S_FULL;
                else if (w_emit && !w_accept) w_state_nxt = S_EMPTY;
            end
            S_FULL:  if (w_emit) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        o_valid        = (r_state != S_EMPTY);
        o_ready        = r_ready;
        w_load_main    = w_accept & ((r_state == S_EMPTY) | ((r_state == S_ONE) & w_emit));
        w_load_skid    = w_accept & (r_state == S_ONE) & !w_emit;
        w_skid_to_main = (r_state == S_FULL) & w_emit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_skid_to_main)   r_main <= r_skid;
            else if (w_load_main) r_main <= i_data;
            if (w_load_skid)      r_skid <= i_data;
        end
    end

    assign o_data = r_main;
endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: format decode + PC-relative add feeding a skid buffer.
// Optional macro IMM_GEN_CSR_EN enables imm_src=101 (Z format, CSR zimm).
`default_nettype none

module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ILEN  = imm_pkg::ILEN
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    imm_gen_pipe_if.slave bus
);
    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (ILEN != 32) begin : g_bad_ilen
        $error("imm_gen_pipe: ILEN must be 32");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            illegal;
    } payload_t;

    localparam int unsigned PAY_W = payload_bits(XLEN);

    payload_t        w_in;
    payload_t        w_out;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_unused;

    // Opcode bits never contribute to any immediate.
    assign w_unused = ^bus.instr[6:0];

    // Size-casting a signed value sign-extends from instr[31] up to XLEN.
    always_comb begin
        w_imm     = '0;
        w_illegal = 1'b0;
        case (bus.imm_src)
            IMM_I: w_imm = XLEN'($signed(bus.instr[31:20]));
            IMM_S: w_imm = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
            IMM_B: w_imm = XLEN'($signed({bus.instr[31], bus.instr[7], bus.instr[30:25],
                                          bus.instr[11:8], 1'b0}));
            IMM_J: w_imm = XLEN'($signed({bus.instr[31], bus.instr[19:12], bus.instr[20],
                                          bus.instr[30:21], 1'b0}));
            IMM_U: w_imm = XLEN'($signed({bus.instr[31:12], 12'b0}));
`ifdef IMM_GEN_CSR_EN
            IMM_Z: w_imm = XLEN'(bus.instr[19:15]);
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_in.imm     = w_imm;
    assign w_in.target  = bus.pc + w_imm;
    assign w_in.illegal = w_illegal;

    imm_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (bus.in_valid),
        .o_ready (bus.in_ready),
        .i_data  (w_in),
        .o_valid (bus.out_valid),
        .i_ready (bus.out_ready),
        .o_data  (w_out)
    );

    assign bus.imm_ext = w_out.imm;
    assign bus.target  = w_out.target;
    assign bus.illegal = w_out.illegal;
endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe at XLEN=32 and XLEN=64.
`default_nettype none

module tb_imm_gen_pipe;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    imm_gen_pipe_if #(.XLEN(32), .ILEN(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .ILEN(32)) bus64 ();

    imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
    imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic v, input logic [31:0] ins, input logic [2:0] src,
                           input logic [31:0] p);
        bus32.in_valid = v;
        bus32.instr    = ins;
        bus32.imm_src  = src;
        bus32.pc       = p;
    endtask

    task automatic out32(input string tag, input logic [31:0] imm, input logic [31:0] tgt,
                         input logic ill);
        chk({tag, ".valid"},   bus32.out_valid, 1'b1);
        chk({tag, ".imm"},     bus32.imm_ext,   imm);
        chk({tag, ".target"},  bus32.target,    tgt);
        chk({tag, ".illegal"}, bus32.illegal,   ill);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive32(1'b0, 32'h0, 3'b000, 32'h0);
        bus32.out_ready = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.instr     = 32'h0;
        bus64.imm_src   = 3'b000;
        bus64.pc        = 64'h0;
        bus64.out_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst.out_valid", bus32.out_valid, 1'b0);
        chk("rst.in_ready",  bus32.in_ready,  1'b0);
        chk("rst.imm",       bus32.imm_ext,   32'h0);
        chk("rst.target",    bus32.target,    32'h0);
        chk("rst.illegal",   bus32.illegal,   1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst.in_ready_rise", bus32.in_ready, 1'b1);

        // I-type
        bus32.out_ready = 1'b1;
        drive32(1'b1, 32'hFFF00093, 3'b000, 32'h0);
        tick();
        drive32(1'b0, 32'h0, 3'b000, 32'h0);
        out32("itype", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        tick();
        chk("itype.drain", bus32.out_valid, 1'b0);

        // B-type
        drive32(1'b1, 32'hFE000EE3, 3'b010, 32'h100);
        tick();
        drive32(1'b0, 32'h0, 3'b000, 32'h0);
        out32("btype", 32'hFFFFFFFC, 32'h000000FC, 1'b0);
        tick();

        // S then J back-to-back
        drive32(1'b1, 32'hFE20AC23, 3'b001, 32'h300);
        tick();
        drive32(1'b1, 32'h0080006F, 3'b011, 32'h200);
        out32("stype", 32'hFFFFFFF8, 32'h000002F8, 1'b0);
        tick();
        drive32(1'b0, 32'h0, 3'b000, 32'h0);
        out32("jtype", 32'h00000008, 32'h00000208, 1'b0);
        tick();
        chk("sj.drain", bus32.out_valid, 1'b0);

        // Backpressure: A, B accepted, C held until ready returns
        bus32.out_ready = 1'b0;
        drive32(1'b1, 32'h00100093, 3'b000, 32'h10);
        tick();
        chk("bp.ready_after_a", bus32.in_ready, 1'b1);
        drive32(1'b1, 32'h00200093, 3'b000, 32'h10);
        tick();
        chk("bp.ready_after_b", bus32.in_ready, 1'b0);
        out32("bp.hold_a", 32'h1, 32'h11, 1'b0);
        drive32(1'b1, 32'h00300093, 3'b000, 32'h10);
        tick();
        chk("bp.ready_full", bus32.in_ready, 1'b0);
        out32("bp.hold_a2", 32'h1, 32'h11, 1'b0);
        bus32.out_ready = 1'b1;
        tick();
        out32("bp.b", 32'h2, 32'h12, 1'b0);
        chk("bp.ready_drain", bus32.in_ready, 1'b1);
        tick();
        drive32(1'b0, 32'h0, 3'b000, 32'h0);
        out32("bp.c", 32'h3, 32'h13, 1'b0);
        tick();
        chk("bp.drain", bus32.out_valid, 1'b0);

        // Illegal encodings
        drive32(1'b1, 32'hFFFFFFFF, 3'b111, 32'h40);
        tick();
        drive32(1'b0, 32'h0, 3'b000, 32'h0);
        out32("illegal111", 32'h0, 32'h40, 1'b1);
        tick();
        drive32(1'b1, 32'h000F8073, 3'b101, 32'h80);
        tick();
        drive32(1'b0, 32'h0, 3'b000, 32'h0);
`ifdef IMM_GEN_CSR_EN
        out32("zfmt", 32'h1F, 32'h9F, 1'b0);
`else
        out32("zfmt", 32'h0, 32'h80, 1'b1);
`endif
        tick();

        // Reset while FULL discards both slots
        bus32.out_ready = 1'b0;
        drive32(1'b1, 32'h00100093, 3'b000, 32'h0);
        tick();
        tick();
        drive32(1'b0, 32'h0, 3'b000, 32'h0);
        chk("full.in_ready", bus32.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rstfull.out_valid", bus32.out_valid, 1'b0);
        chk("rstfull.in_ready",  bus32.in_ready,  1'b0);
        tick();
        rst_n = 1'b1;
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstfull.no_emit", bus32.out_valid, 1'b0);
        end

        // XLEN=64 instance
        bus64.in_valid = 1'b1;
        bus64.instr    = 32'h80000037;
        bus64.imm_src  = 3'b100;
        bus64.pc       = 64'h1000;
        tick();
        bus64.instr    = 32'hFFF00093;
        bus64.imm_src  = 3'b000;
        bus64.pc       = 64'h0;
        chk("u64.valid",  bus64.out_valid, 1'b1);
        chk("u64.imm",    bus64.imm_ext,   64'hFFFFFFFF80000000);
        chk("u64.target", bus64.target,    64'hFFFFFFFF80001000);
        tick();
        bus64.in_valid = 1'b0;
        chk("i64.imm",    bus64.imm_ext,   64'hFFFFFFFFFFFFFFFF);
        chk("i64.target", bus64.target,    64'hFFFFFFFFFFFFFFFF);
        tick();
        chk("i64.drain",  bus64.out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
